// File: rtl/sitcpxg_rx_reader.sv
`timescale 1ns/1ps
// sitcpxg_rx_reader
//   Consumer side of the SiTCP-XG TCP receive buffer. Holds the 64-bit RX RAM
//   that the core writes through USER_RX_WADR/WENB/WDAT (big-endian: byte
//   offset 0 = WDAT[63:56] = WENB[7]). Received bytes are drained to a
//   valid/ready stream, and the consumed byte pointer is returned on
//   USER_RX_RADR. Receive-buffer clear requests are serviced once the buffer is idle.
// Ports
//   CLK, RSTn          XGMII clock, async active-low reset
//   USER_RX_SIZE       usable buffer size in bytes (constant)
//   USER_RX_CLR_ENB/REQ  core may clear / one-cycle clear request
//   USER_RX_RADR       read pointer in bytes
//   USER_RX_WADR/WENB/WDAT  core writes into the RX RAM
//   M_DATA/M_BYTES/M_VALID/M_READY  output stream; data left-justified
module sitcpxg_rx_reader #(
  parameter int ADDR_W = 13
) (
  input  logic        CLK,
  input  logic        RSTn,
  output logic [15:0] USER_RX_SIZE,
  input  logic        USER_RX_CLR_ENB,
  output logic        USER_RX_CLR_REQ,
  output logic [15:0] USER_RX_RADR,
  input  logic [15:0] USER_RX_WADR,
  input  logic [7:0]  USER_RX_WENB,
  input  logic [63:0] USER_RX_WDAT,
  output logic [63:0] M_DATA,
  output logic [3:0]  M_BYTES,
  output logic        M_VALID,
  input  logic        M_READY
);

  localparam int PW    = ADDR_W + 3;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [16:0] RX_SIZE = 17'((1 << PW) - 16);

  logic [63:0]       mem [DEPTH];
  logic [63:0]       rd_word_q;
  logic [ADDR_W-1:0] waddr;
  logic              wr_en;
  logic [3:0]        wr_len;
  logic              unused_wadr;

  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, radr_q, radr_d;
  logic [PW-1:0]     avail;
  logic [3:0]        word_room, rd_n;
  logic [2:0]        occ;
  logic              issue, push, pop, clr_fire;

  logic              infl_q, infl_d;
  logic [2:0]        infl_off_q, infl_off_d;
  logic [3:0]        infl_n_q, infl_n_d;
  logic [PW-1:0]     infl_ptr_q, infl_ptr_d;

  logic [1:0][63:0]  fifo_data_q, fifo_data_d;
  logic [1:0][3:0]   fifo_bytes_q, fifo_bytes_d;
  logic              head_q, head_d, tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              armed_q, armed_d;

  assign waddr       = USER_RX_WADR[ADDR_W+2:3];
  assign wr_en       = |USER_RX_WENB;
  // Upper address bits are outside the buffer and the byte offset is implied by WENB.
  assign unused_wadr = ^USER_RX_WADR;

  // Write end = 8 - index of the lowest enabled WENB bit (last match wins).
  always_comb begin
    wr_len = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (USER_RX_WENB[i]) wr_len = 4'(8 - i);
    end
  end

  assign avail     = wptr_q - rptr_q;
  assign word_room = 4'd8 - {1'b0, rptr_q[2:0]};
  // A read never crosses a RAM word, so it is capped by the rest of the word.
  assign rd_n      = (avail < PW'(word_room)) ? avail[3:0] : word_room;

  assign M_VALID   = (cnt_q != 2'd0);
  assign M_DATA    = fifo_data_q[head_q];
  assign M_BYTES   = fifo_bytes_q[head_q];
  assign pop       = M_VALID & M_READY;
  assign push      = infl_q;
  // FIFO slots already promised: queued + in flight, less what leaves this cycle.
  assign occ       = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
  assign issue     = (avail != '0) && (occ < 3'd2);
  assign clr_fire  = USER_RX_CLR_ENB && armed_q && (avail == '0) &&
                     (cnt_q == 2'd0) && !infl_q;

  assign USER_RX_CLR_REQ = clr_fire;
  assign USER_RX_RADR    = 16'(radr_q);
  assign USER_RX_SIZE    = RX_SIZE[15:0];

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    radr_d       = radr_q;
    infl_d       = issue;
    infl_off_d   = infl_off_q;
    infl_n_d     = infl_n_q;
    infl_ptr_d   = infl_ptr_q;
    fifo_data_d  = fifo_data_q;
    fifo_bytes_d = fifo_bytes_q;
    head_d       = head_q;
    tail_d       = tail_q;
    armed_d      = armed_q;

    if (wr_en) wptr_d = {waddr, 3'b000} + PW'(wr_len);

    if (issue) begin
      rptr_d     = rptr_q + PW'(rd_n);
      infl_off_d = rptr_q[2:0];
      infl_n_d   = rd_n;
      infl_ptr_d = rptr_q + PW'(rd_n);
    end

    if (push) begin
      fifo_data_d[tail_q]  = rd_word_q << {infl_off_q, 3'b000};
      fifo_bytes_d[tail_q] = infl_n_q;
      tail_d               = ~tail_q;
      radr_d               = infl_ptr_q;
    end
    if (pop) head_d = ~head_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);

    // Re-arm only after CLR_ENB has been seen low, so one enable gives one pulse.
    if (!USER_RX_CLR_ENB) armed_d = 1'b1;
    else if (clr_fire)    armed_d = 1'b0;

    // Clear overrides a coincident write; nothing is pending when it fires.
    if (clr_fire) begin
      wptr_d = '0;
      rptr_d = '0;
      radr_d = '0;
    end
  end

  // RX RAM: byte-lane writes, registered read-first port.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 8; i++) begin
      if (USER_RX_WENB[i]) mem[waddr][8*i +: 8] <= USER_RX_WDAT[8*i +: 8];
    end
    if (issue) rd_word_q <= mem[rptr_q[PW-1:3]];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      radr_q       <= '0;
      infl_q       <= 1'b0;
      infl_off_q   <= '0;
      infl_n_q     <= '0;
      infl_ptr_q   <= '0;
      fifo_data_q  <= '0;
      fifo_bytes_q <= '0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      cnt_q        <= '0;
      // Disarmed out of reset so CLR_REQ stays low while RSTn is asserted.
      armed_q      <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      radr_q       <= radr_d;
      infl_q       <= infl_d;
      infl_off_q   <= infl_off_d;
      infl_n_q     <= infl_n_d;
      infl_ptr_q   <= infl_ptr_d;
      fifo_data_q  <= fifo_data_d;
      fifo_bytes_q <= fifo_bytes_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
    end
  end

endmodule
